pwm_bank: RTL
=============

Name: pwm_bank

Overview:
Memory-mapped, N-channel PWM/digital output bank on the core's peripheral bus. It replaces the single fixed PWM and digital-output pair in the peripherals block. All channels share one programmable period counter. Each channel has its own duty register and its own digital/PWM mode bit. Duty and period writes are double-buffered and take effect only at a period boundary, so no output glitches.

Parameters:
N_CH, 16, number of output channels (1..32)
CNT_W, 16, width of period counter, PERIOD and DUTY registers (1..32)
ADDR_W, 7, byte-address width; must cover 0x14 + 4*(N_CH-1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
A  input  ADDR_W  byte address; A[1:0] ignored, decode on A[ADDR_W-1:2]
WD  input  32  write data
WE  input  1  write enable, qualified by this block's chip select upstream
RD  output  32  read data, combinational from A
out  output  N_CH  registered channel outputs (to LEDs/pins)
period_tick  output  1  one-cycle pulse at each counter wrap while enabled

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Register map (byte offsets):
  - 0x00 CTRL: [0] EN (RW), [1] UPD_PEND (RO), other bits read 0.
  - 0x04 PERIOD: shadow, RW, CNT_W bits.
  - 0x08 COUNT: RO, current counter value.
  - 0x0C MODE: RW, N_CH bits; 1 = PWM, 0 = digital.
  - 0x10 DOUT: RW, N_CH bits.
  - 0x14+4k DUTY[k]: shadow, RW, CNT_W bits, for k < N_CH.
- Reads:
  - Upper bits are zero-extended.
  - Unmapped addresses read 0.
  - Writes to RO fields and unmapped addresses are ignored.
  - RD has zero latency (combinational).
- Reset: every register, shadow and active copy, the counter, out and period_tick go to 0.
- Counter, EN=1:
  - If cnt == period_act: cnt <= 0, period_tick = 1 for that cycle.
  - Otherwise cnt <= cnt+1.
  - The period is period_act+1 cycles.
- Counter, EN=0: cnt is held at 0, period_tick = 0, and active copies load from shadows every cycle (immediate update). On EN 0->1 counting starts at 0 on the following cycle.
- Shadow load with EN=1:
  - Active PERIOD/DUTY copies load from shadows only on the wrap cycle, and only if UPD_PEND = 1.
  - The load clears UPD_PEND.
  - Any write to PERIOD or to any DUTY sets UPD_PEND.
- Write coinciding with wrap: the load uses the pre-write shadow values and UPD_PEND stays set. The new value is applied at the next wrap.
- PWM compare: pwm[k] = (cnt < duty_act[k]).
  - duty 0 gives constant low.
  - duty > period_act gives constant high.
  - When PERIOD = 0, the output is 1 exactly when duty > 0.
  - pwm[k] is forced low while EN = 0.
- Output: out[k] <= MODE[k] ? pwm[k] : DOUT[k], registered.
  - Latency is one cycle from the cnt/MODE/DOUT change to out.
  - A write to MODE or DOUT is visible on out 2 cycles after the WE edge.
- Changing PERIOD so that the new period_act < cnt cannot occur, because the load happens only at wrap (cnt becomes 0).

Test Plan:
- Reset, then read all registers -> all read 0; out = 0. Assert rst_n low mid-run -> out and COUNT read 0 immediately (asynchronous).
- PERIOD=9, DUTY[0]=3, MODE=0x1, EN=1 -> out[0] high 3 of every 10 cycles; period_tick every 10 cycles; COUNT sweeps 0..9.
- While running, write DUTY[0]=7 mid-period -> UPD_PEND reads 1. The duty stays 3 until the wrap, then becomes 7 and UPD_PEND reads 0. Repeat with the write on the exact wrap cycle -> 3 persists one more full period.
- DUTY[1]=0, DUTY[2]=10, DUTY[3]=0xFFFF with PERIOD=9, MODE=0xE -> out[1] constant 0; out[2] and out[3] constant 1.
- MODE=0, DOUT=0xA5A5 -> out = 0xA5A5 two cycles after the write. Set MODE bit 0 -> out[0] follows PWM while the other bits keep their DOUT values.
- EN=0 with DUTY[0]=5 written -> COUNT stays 0 and out[0] = 0 (PWM mode). Set EN=1 -> the first period already uses duty 5.

Source files
------------

// File: rtl/pwm_bank.sv
// N-channel PWM / digital output bank sharing one period counter, with duty and period
// writes double-buffered to the period wrap. RD is combinational, out is one cycle after cnt/MODE/DOUT, and there is no backpressure.
module pwm_bank #(
  parameter int N_CH   = 16,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       WD,
  input  logic              WE,
  output logic [31:0]       RD,
  output logic [N_CH-1:0]   out,
  output logic              period_tick
);

  localparam int WI_W = ADDR_W - 2;
  localparam logic [WI_W-1:0] IDX_CTRL   = WI_W'(0);
  localparam logic [WI_W-1:0] IDX_PERIOD = WI_W'(1);
  localparam logic [WI_W-1:0] IDX_COUNT  = WI_W'(2);
  localparam logic [WI_W-1:0] IDX_MODE   = WI_W'(3);
  localparam logic [WI_W-1:0] IDX_DOUT   = WI_W'(4);

  logic [WI_W-1:0]  widx;
  logic             en;
  logic             upd_pend;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] cnt;
  logic [N_CH-1:0]  mode;
  logic [N_CH-1:0]  dout;
  logic [CNT_W-1:0] duty_sh  [N_CH];
  logic [CNT_W-1:0] duty_act [N_CH];

  logic             wr_ctrl, wr_period, wr_mode, wr_dout;
  logic [N_CH-1:0]  wr_duty;
  logic             wrap, load, shadow_wr;
  logic [N_CH-1:0]  pwm;

  assign widx      = A[ADDR_W-1:2];
  assign wr_ctrl   = WE && (widx == IDX_CTRL);
  assign wr_period = WE && (widx == IDX_PERIOD);
  assign wr_mode   = WE && (widx == IDX_MODE);
  assign wr_dout   = WE && (widx == IDX_DOUT);

  always_comb begin
    wr_duty = '0;
    pwm     = '0;
    for (int k = 0; k < N_CH; k++) begin
      wr_duty[k] = WE && (widx == WI_W'(5 + k));
      pwm[k]     = en && (cnt < duty_act[k]);
    end
  end

  assign wrap        = en && (cnt == period_act);
  assign period_tick = wrap;
  // While disabled the actives track the shadows every cycle; when enabled only at a pending wrap.
  assign load        = !en || (wrap && upd_pend);
  assign shadow_wr   = wr_period || (|wr_duty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en         <= 1'b0;
      upd_pend   <= 1'b0;
      period_sh  <= '0;
      period_act <= '0;
      cnt        <= '0;
      mode       <= '0;
      dout       <= '0;
      out        <= '0;
      for (int k = 0; k < N_CH; k++) begin
        duty_sh[k]  <= '0;
        duty_act[k] <= '0;
      end
    end else begin
      if (!en || wrap) cnt <= '0;
      else             cnt <= cnt + 1'b1;

      // A shadow write on the load cycle keeps the flag: the load took the old shadow value.
      if (shadow_wr) upd_pend <= 1'b1;
      else if (load) upd_pend <= 1'b0;

      if (load) begin
        period_act <= period_sh;
        for (int k = 0; k < N_CH; k++) duty_act[k] <= duty_sh[k];
      end

      if (wr_ctrl)   en        <= WD[0];
      if (wr_period) period_sh <= WD[CNT_W-1:0];
      if (wr_mode)   mode      <= WD[N_CH-1:0];
      if (wr_dout)   dout      <= WD[N_CH-1:0];
      for (int k = 0; k < N_CH; k++)
        if (wr_duty[k]) duty_sh[k] <= WD[CNT_W-1:0];

      out <= (mode & pwm) | (~mode & dout);
    end
  end

  always_comb begin
    RD = '0;
    if      (widx == IDX_CTRL)   RD = {30'd0, upd_pend, en};
    else if (widx == IDX_PERIOD) RD = 32'(period_sh);
    else if (widx == IDX_COUNT)  RD = 32'(cnt);
    else if (widx == IDX_MODE)   RD = 32'(mode);
    else if (widx == IDX_DOUT)   RD = 32'(dout);
    else begin
      for (int k = 0; k < N_CH; k++)
        if (widx == WI_W'(5 + k)) RD = 32'(duty_sh[k]);
    end
  end

endmodule
